cpu_debug_cmd_sysclk: RTL and testbench

Parametrised system-clock half of the CPU JTAG debug slave. Update-IR and update-DR levels arrive from the TCK domain; this block synchronises them, edge-detects them and snapshots the shift register into jdo. It issues one-hot action or no-action pulses per IR code and queues every captured command in a small FIFO, with a ready/valid drain port and sticky overflow. It is the generalised successor to the fixed 2-bit-IR / 38-bit-SR sysclk decoder.

---
 rtl/cpu_debug_cmd_sysclk_pkg.sv | 36 +++
 rtl/cpu_debug_cmd_sysclk_fifo.sv | 122 ++++++++++++
 rtl/cpu_debug_cmd_sysclk.sv | 167 ++++++++++++++++
 tb/tb_cpu_debug_cmd_sysclk.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_debug_cmd_sysclk_pkg.sv
// ---------------------------------------------------------------------------
// cpu_debug_cmd_sysclk_pkg
//
// Purpose: definitions shared by the system-clock half of the CPU JTAG debug
// slave. Holds the default geometry of the classic debug slave (2-bit IR,
// 38-bit shift register), the IR code names, and the layout of one queued
// debug command.
//
// Contents:
//   DBG_*          default parameter values for the sysclk decoder
//   dbg_ir_e       IR code names (OCIMEM_A, OCIMEM_B, BREAK, TRACECTRL)
//   dbg_cmd_t      one command entry {ir, data} at the default widths
// ---------------------------------------------------------------------------
package cpu_debug_cmd_sysclk_pkg;

    localparam int DBG_IR_W        = 2;
    localparam int DBG_SR_W        = 38;
    localparam int DBG_SYNC_STAGES = 2;
    localparam int DBG_FIFO_DEPTH  = 4;
    localparam int DBG_ACTION_BIT  = 35;

    // IR codes understood by the debug slave at the default 2-bit IR width
    typedef enum logic [DBG_IR_W-1:0] {
        IR_OCIMEM_A  = 2'b00,
        IR_OCIMEM_B  = 2'b01,
        IR_BREAK     = 2'b10,
        IR_TRACECTRL = 2'b11
    } dbg_ir_e;

    // One captured command: the IR in force plus the DR snapshot
    typedef struct packed {
        logic [DBG_IR_W-1:0] ir;
        logic [DBG_SR_W-1:0] data;
    } dbg_cmd_t;

endpackage

// File: rtl/cpu_debug_cmd_sysclk_fifo.sv
// ---------------------------------------------------------------------------
// cpu_debug_cmd_fifo
//
// Purpose: show-ahead synchronous command queue. The head entry is presented
// on head_ir/head_data whenever valid is high. A push that finds the queue
// full with no pop in the same cycle is dropped and sets the sticky overflow
// flag; a push on a full queue with a simultaneous pop is accepted.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   push            write request, push_ir/push_data are the entry
//   pop             read request (ignored when empty)
//   overflow_clr    clears overflow on the next edge (a drop wins)
//   valid           queue non-empty
//   head_ir/_data   head entry, meaningful while valid
//   count           occupancy, 0..DEPTH
//   overflow        sticky dropped-entry flag
// ---------------------------------------------------------------------------
module cpu_debug_cmd_fifo
    import cpu_debug_cmd_sysclk_pkg::*;
#(
    parameter int IR_W  = DBG_IR_W,
    parameter int SR_W  = DBG_SR_W,
    parameter int DEPTH = DBG_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [IR_W-1:0]          push_ir,
    input  logic [SR_W-1:0]          push_data,
    input  logic                     pop,
    input  logic                     overflow_clr,
    output logic                     valid,
    output logic [IR_W-1:0]          head_ir,
    output logic [SR_W-1:0]          head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    // Queue bookkeeping. A pop frees a slot in the same cycle, so a push on a
    // full queue only drops when nothing leaves. Pointers are power-of-two
    // wide and wrap on their own.
    always_comb begin
        full       = (count_q == CNT_W'(DEPTH));
        do_pop     = pop && (count_q != '0);
        do_push    = push && (!full || do_pop);
        drop       = push && full && !do_pop;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (do_push) begin
            mem_d[wr_ptr_q].ir   = push_ir;
            mem_d[wr_ptr_q].data = push_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end

        // A drop in the same cycle as a clear leaves the flag set
        if (overflow_clr) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Storage, pointers, occupancy and sticky flag; reset flushes everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Head is forced to zero when empty so stale entries never leak out
    assign valid     = (count_q != '0);
    assign head_ir   = valid ? mem_q[rd_ptr_q].ir   : '0;
    assign head_data = valid ? mem_q[rd_ptr_q].data : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: rtl/cpu_debug_cmd_sysclk.sv
// ---------------------------------------------------------------------------
// cpu_debug_cmd_sysclk
//
// Purpose: system-clock half of the CPU JTAG debug slave. The update-IR and
// update-DR levels from the TCK domain are synchronised and edge-detected.
// An update-IR rise latches ir_in; an update-DR rise snapshots sr into jdo
// and, one cycle later, fires a one-hot action / no-action pulse indexed by
// the latched IR and queues {ir_latched, jdo} in a small command FIFO.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   ir_in, vs_uir              IR and update-IR level from the TCK domain
//   sr, vs_udr                 shift register and update-DR level
//   ir_latched, jdo            last IR captured / last DR snapshot
//   take_action                one-cycle pulse, jdo[ACTION_BIT] = 1
//   take_no_action             one-cycle pulse, jdo[ACTION_BIT] = 0
//   cmd_valid/ready/ir/data    show-ahead drain port of the command queue
//   fifo_count                 queue occupancy
//   overflow, overflow_clr     sticky dropped-command flag and its clear
// ---------------------------------------------------------------------------
module cpu_debug_cmd_sysclk
    import cpu_debug_cmd_sysclk_pkg::*;
#(
    parameter int IR_W        = DBG_IR_W,
    parameter int SR_W        = DBG_SR_W,
    parameter int SYNC_STAGES = DBG_SYNC_STAGES,
    parameter int FIFO_DEPTH  = DBG_FIFO_DEPTH,
    parameter int ACTION_BIT  = DBG_ACTION_BIT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [SR_W-1:0]               sr,
    input  logic                          vs_uir,
    input  logic                          vs_udr,
    output logic [IR_W-1:0]               ir_latched,
    output logic [SR_W-1:0]               jdo,
    output logic [2**IR_W-1:0]            take_action,
    output logic [2**IR_W-1:0]            take_no_action,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [IR_W-1:0]               cmd_ir,
    output logic [SR_W-1:0]               cmd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int NUM_IR = 2**IR_W;
    localparam int LAST   = SYNC_STAGES - 1;
    localparam int SUP_W  = $clog2(SYNC_STAGES + 2);
    localparam logic [SUP_W-1:0] SUP_INIT = SUP_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic                   uir_hist_q, uir_hist_d;
    logic                   udr_hist_q, udr_hist_d;
    logic [SUP_W-1:0]       suppress_q, suppress_d;
    logic [IR_W-1:0]        ir_latched_q, ir_latched_d;
    logic [SR_W-1:0]        jdo_q, jdo_d;
    logic                   pending_q, pending_d;
    logic [NUM_IR-1:0]      take_action_q, take_action_d;
    logic [NUM_IR-1:0]      take_no_action_q, take_no_action_d;
    logic                   guard_open;
    logic                   uir_rise;
    logic                   udr_rise;

    // Synchroniser chains: stage 0 samples the asynchronous level, each later
    // stage takes the one before it
    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        if (g == 0) begin : g_first
            assign uir_sync_d[g] = vs_uir;
            assign udr_sync_d[g] = vs_udr;
        end else begin : g_chain
            assign uir_sync_d[g] = uir_sync_q[g-1];
            assign udr_sync_d[g] = udr_sync_q[g-1];
        end
    end

    // Edge detection, post-reset guard and command capture. The guard counter
    // covers the synchroniser depth plus history flop, so a level already high
    // when reset drops has drained through before rises are honoured. The
    // pulse and the queue push happen one cycle after the DR rise, using the
    // IR in force then, so a simultaneous IR update applies to this command.
    always_comb begin
        guard_open       = (suppress_q == '0);
        suppress_d       = guard_open ? suppress_q : suppress_q - 1'b1;
        uir_hist_d       = uir_sync_q[LAST];
        udr_hist_d       = udr_sync_q[LAST];
        uir_rise         = guard_open && uir_sync_q[LAST] && !uir_hist_q;
        udr_rise         = guard_open && udr_sync_q[LAST] && !udr_hist_q;
        ir_latched_d     = ir_latched_q;
        jdo_d            = jdo_q;
        pending_d        = udr_rise;
        take_action_d    = '0;
        take_no_action_d = '0;

        if (uir_rise) begin
            ir_latched_d = ir_in;
        end
        if (udr_rise) begin
            jdo_d = sr;
        end
        if (pending_q) begin
            if (jdo_q[ACTION_BIT]) begin
                take_action_d[ir_latched_q] = 1'b1;
            end else begin
                take_no_action_d[ir_latched_q] = 1'b1;
            end
        end
    end

    // State registers; reset discards any in-flight rise or pending pulse and
    // re-arms the guard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uir_sync_q       <= '0;
            udr_sync_q       <= '0;
            uir_hist_q       <= 1'b0;
            udr_hist_q       <= 1'b0;
            suppress_q       <= SUP_INIT;
            ir_latched_q     <= '0;
            jdo_q            <= '0;
            pending_q        <= 1'b0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
        end else begin
            uir_sync_q       <= uir_sync_d;
            udr_sync_q       <= udr_sync_d;
            uir_hist_q       <= uir_hist_d;
            udr_hist_q       <= udr_hist_d;
            suppress_q       <= suppress_d;
            ir_latched_q     <= ir_latched_d;
            jdo_q            <= jdo_d;
            pending_q        <= pending_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
        end
    end

    // Every captured command is queued; a full queue drops it but the pulse
    // above is still issued
    cpu_debug_cmd_fifo #(
        .IR_W  (IR_W),
        .SR_W  (SR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (pending_q),
        .push_ir      (ir_latched_q),
        .push_data    (jdo_q),
        .pop          (cmd_ready),
        .overflow_clr (overflow_clr),
        .valid        (cmd_valid),
        .head_ir      (cmd_ir),
        .head_data    (cmd_data),
        .count        (fifo_count),
        .overflow     (overflow)
    );

    assign ir_latched     = ir_latched_q;
    assign jdo            = jdo_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;

endmodule

// File: tb/tb_cpu_debug_cmd_sysclk.sv
// ---------------------------------------------------------------------------
// tb_cpu_debug_cmd_sysclk
//
// Purpose: self-checking bench for cpu_debug_cmd_sysclk. A behavioural model
// tracks the level samples seen at each edge, derives rises from the stated
// synchroniser latency and guard window, and keeps the command queue as a
// plain SystemVerilog queue. Directed sequences are followed by randomized
// traffic, with literal checks pinning key scenarios.
// ---------------------------------------------------------------------------
module tb_cpu_debug_cmd_sysclk;

    localparam int IR_W   = 2;
    localparam int SR_W   = 38;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 4;
    localparam int AB     = 35;
    localparam int NPULSE = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [IR_W-1:0]   ir_in;
    logic [SR_W-1:0]   sr;
    logic              vs_uir;
    logic              vs_udr;
    logic [IR_W-1:0]   ir_latched;
    logic [SR_W-1:0]   jdo;
    logic [NPULSE-1:0] take_action;
    logic [NPULSE-1:0] take_no_action;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [IR_W-1:0]   cmd_ir;
    logic [SR_W-1:0]   cmd_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow;
    logic              overflow_clr;

    int vectors     = 0;
    int miscompares = 0;
    int pulse_seen  = 0;

    // Model state
    bit                     uir_hist[$];
    bit                     udr_hist[$];
    int                     edge_no;
    logic [IR_W-1:0]        m_ir;
    logic [SR_W-1:0]        m_jdo;
    bit                     m_pending;
    logic [NPULSE-1:0]      m_act;
    logic [NPULSE-1:0]      m_noact;
    logic [IR_W+SR_W-1:0]   m_fifo[$];
    bit                     m_ovf;

    // Free-running system clock
    always #5 clk = ~clk;

    cpu_debug_cmd_sysclk #(
        .IR_W        (IR_W),
        .SR_W        (SR_W),
        .SYNC_STAGES (SYNC),
        .FIFO_DEPTH  (DEPTH),
        .ACTION_BIT  (AB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ir_in          (ir_in),
        .sr             (sr),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .ir_latched     (ir_latched),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_ir         (cmd_ir),
        .cmd_data       (cmd_data),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .overflow_clr   (overflow_clr)
    );

    // One comparison: counts it and reports a miss
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit hist_at(input bit q[$], input int j);
        return (j < q.size()) ? q[j] : 1'b0;
    endfunction

    task automatic modelReset();
        uir_hist.delete();
        udr_hist.delete();
        m_fifo.delete();
        edge_no   = 0;
        m_ir      = '0;
        m_jdo     = '0;
        m_pending = 1'b0;
        m_act     = '0;
        m_noact   = '0;
        m_ovf     = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs held at that edge.
    // A level first sampled high at edge k counts as a rise at edge k+SYNC
    // if the sample before it was low; rises before edge SYNC+2 after reset
    // release fall inside the guard window and are ignored.
    task automatic modelStep();
        bit                   rise_u;
        bit                   rise_d;
        logic [IR_W+SR_W-1:0] entry;
        edge_no++;
        uir_hist.push_front(vs_uir);
        udr_hist.push_front(vs_udr);
        if (uir_hist.size() > SYNC + 2) void'(uir_hist.pop_back());
        if (udr_hist.size() > SYNC + 2) void'(udr_hist.pop_back());
        rise_u = (edge_no >= SYNC + 2) && hist_at(uir_hist, SYNC) && !hist_at(uir_hist, SYNC + 1);
        rise_d = (edge_no >= SYNC + 2) && hist_at(udr_hist, SYNC) && !hist_at(udr_hist, SYNC + 1);

        m_act   = '0;
        m_noact = '0;
        entry   = {m_ir, m_jdo};
        if (m_pending) begin
            if (m_jdo[AB]) m_act[m_ir] = 1'b1;
            else           m_noact[m_ir] = 1'b1;
        end
        if (cmd_ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (overflow_clr) m_ovf = 1'b0;
        if (m_pending) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(entry);
            else                       m_ovf = 1'b1;
        end
        if (rise_u) m_ir = ir_in;
        if (rise_d) m_jdo = sr;
        m_pending = rise_d;
    endtask

    task automatic compareAll();
        logic [IR_W+SR_W-1:0] head;
        checkOutput("ir_latched", 64'(ir_latched), 64'(m_ir));
        checkOutput("jdo", 64'(jdo), 64'(m_jdo));
        checkOutput("take_action", 64'(take_action), 64'(m_act));
        checkOutput("take_no_action", 64'(take_no_action), 64'(m_noact));
        checkOutput("cmd_valid", 64'(cmd_valid), 64'(m_fifo.size() > 0));
        checkOutput("fifo_count", 64'(fifo_count), 64'(m_fifo.size()));
        checkOutput("overflow", 64'(overflow), 64'(m_ovf));
        if (m_fifo.size() > 0) begin
            head = m_fifo[0];
            checkOutput("cmd_ir", 64'(cmd_ir), 64'(head[IR_W+SR_W-1:SR_W]));
            checkOutput("cmd_data", 64'(cmd_data), 64'(head[SR_W-1:0]));
        end
    endtask

    // One clock: wait for the edge, let outputs settle, step model, compare
    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) modelReset();
        else       modelStep();
        compareAll();
        if ((take_action != '0) || (take_no_action != '0)) pulse_seen++;
    endtask

    task automatic applyStimulus(input bit uir, input bit udr, input bit rdy, input bit clr);
        vs_uir       = uir;
        vs_udr       = udr;
        cmd_ready    = rdy;
        overflow_clr = clr;
        tick();
    endtask

    // IR update followed by a DR update carrying data
    task automatic sendCommand(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] data);
        ir_in = ir;
        applyStimulus(1, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0);
        sr = data;
        applyStimulus(0, 1, 0, 0);
        repeat (5) applyStimulus(0, 0, 0, 0);
    endtask

    task automatic drain();
        repeat (DEPTH + 1) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
    endtask

    initial begin
        logic [SR_W-1:0] data;
        reset        = 1'b1;
        ir_in        = '0;
        sr           = '0;
        vs_uir       = 1'b0;
        vs_udr       = 1'b1;
        cmd_ready    = 1'b0;
        overflow_clr = 1'b0;

        // Reset guard: DR level already high at release
        repeat (2) tick();
        reset      = 1'b0;
        pulse_seen = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("guard_cmd_valid", 64'(cmd_valid), 64'd0);
        end
        checkOutput("guard_pulses", 64'(pulse_seen), 64'd0);
        repeat (2) applyStimulus(0, 0, 0, 0);
        sr = 38'h12_3456_789A;
        applyStimulus(0, 1, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0);
        checkOutput("guard_one_cmd", 64'(fifo_count), 64'd1);
        checkOutput("guard_one_pulse", 64'(pulse_seen), 64'd1);
        drain();

        // Action decode, pulse SYNC+1 edges after the first high sample
        ir_in = 2'b01;
        applyStimulus(1, 0, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0);
        sr = 38'h08_0000_00AA;
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("action_early", 64'(take_action), 64'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("action_pulse", 64'(take_action), 64'b0010);
        checkOutput("action_jdo", 64'(jdo), 64'h08_0000_00AA);
        applyStimulus(0, 0, 0, 0);
        checkOutput("action_one_cycle", 64'(take_action), 64'd0);
        drain();

        // No-action decode and FIFO head contents
        pulse_seen = 0;
        sendCommand(2'b11, 38'h37_1234_5678);
        checkOutput("noact_pulses", 64'(pulse_seen), 64'd1);
        checkOutput("noact_head_ir", 64'(cmd_ir), 64'd3);
        checkOutput("noact_head_data", 64'(cmd_data), 64'h37_1234_5678);
        drain();

        // Overflow: five commands into four slots
        applyStimulus(0, 0, 0, 1);
        pulse_seen = 0;
        for (int i = 0; i < 5; i++) begin
            data = 38'(64'h1000 + i) | 38'(i % 2) << AB;
            sendCommand(IR_W'(i), data);
        end
        checkOutput("ovf_count", 64'(fifo_count), 64'd4);
        checkOutput("ovf_flag", 64'(overflow), 64'd1);
        checkOutput("ovf_pulses", 64'(pulse_seen), 64'd5);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ovf_cleared", 64'(overflow), 64'd0);

        // Full queue with pop on the push edge
        sr = 38'h2A_AAAA_5555;
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("full_pop_count", 64'(fifo_count), 64'd4);
        checkOutput("full_pop_ovf", 64'(overflow), 64'd0);
        drain();

        // Reset with three queued entries and a DR rise in flight
        for (int i = 0; i < 3; i++) sendCommand(2'b10, 38'(64'hA0 + i));
        checkOutput("midq_count", 64'(fifo_count), 64'd3);
        sr = 38'h3F_0000_0001;
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) applyStimulus(0, 0, 0, 0);
        reset      = 1'b0;
        pulse_seen = 0;
        repeat (10) applyStimulus(0, 0, 0, 0);
        checkOutput("midq_flushed", 64'(fifo_count), 64'd0);
        checkOutput("midq_ir", 64'(ir_latched), 64'd0);
        checkOutput("midq_pulses", 64'(pulse_seen), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit nu;
            bit nd;
            nu = vs_uir ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
            nd = vs_udr ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
            if (!vs_uir) ir_in = IR_W'($urandom_range(0, 3));
            if (!vs_udr) sr = SR_W'({$urandom(), $urandom()});
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                applyStimulus(0, 0, 0, 0);
                reset = 1'b0;
            end
            applyStimulus(nu, nd, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
